multiplexing_sequencer: RTL



---
 rtl/mux_seq_pkg.sv | 21 ++
 rtl/bundle_popcount.sv | 20 ++
 rtl/multiplexing_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the NAND-multiplexing sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_seq_pkg;

    localparam int PASS_W = 4;  // pass index width; RESTORE_PASSES tops out at 15
    localparam int WAIT_W = 4;  // latency countdown width; MU_LATENCY tops out at 15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2,
        HOLD = 2'd3
    } state_e;

    // Bits needed to hold a popcount of 0..n
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bundle_popcount.sv
// Combinational popcount of an N-wire bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: bundle_i - bundle to count; count_o - number of ones in bundle_i.
module bundle_popcount #(
    parameter  int N  = 10,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bundle_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + CW'(bundle_i[i]);
        end
    end

endmodule

// File: rtl/multiplexing_sequencer.sv
// Time-shares one multiplexing_unit: executive NAND pass on (x,y), then
// RESTORE_PASSES restorative passes, then popcount threshold decision.
// Latency: accept to out_valid_o = (RESTORE_PASSES+1)*(MU_LATENCY+1)+1 cycles.
// Backpressure: one job in flight; in_ready_o low from accept until the result
// handshake; the result is held in HOLD until out_ready_i.
// Ports: in_* / x_i / y_i - operand handshake; mu_* - shared unit interface;
// out_* / z_o / count_o / decision_o / ambiguous_o - result handshake;
// pass_o - index of the pass in flight (0 = executive).
module multiplexing_sequencer
    import mux_seq_pkg::*;
#(
    parameter int N              = 10,
    parameter int MU_LATENCY     = 2,
    parameter int RESTORE_PASSES = 2,
    parameter int THRESH_HI      = 7,
    parameter int THRESH_LO      = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [N-1:0]             x_i,
    input  logic [N-1:0]             y_i,
    output logic [N-1:0]             mu_x_o,
    output logic [N-1:0]             mu_y_o,
    input  logic [N-1:0]             mu_z_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [N-1:0]             z_o,
    output logic [$clog2(N+1)-1:0]   count_o,
    output logic                     decision_o,
    output logic                     ambiguous_o,
    output logic [3:0]               pass_o
);

    localparam int CW = count_width(N);
    localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(MU_LATENCY);
    localparam logic [PASS_W-1:0] LAST_PASS  = PASS_W'(RESTORE_PASSES);
    localparam logic [CW-1:0]     HI         = CW'(THRESH_HI);
    localparam logic [CW-1:0]     LO         = CW'(THRESH_LO);

    state_e              state_q,     state_d;
    logic [WAIT_W-1:0]   wait_q,      wait_d;
    logic [PASS_W-1:0]   pass_q,      pass_d;
    logic                in_ready_q,  in_ready_d;
    logic [N-1:0]        mu_x_q,      mu_x_d;
    logic [N-1:0]        mu_y_q,      mu_y_d;
    logic [N-1:0]        bundle_q,    bundle_d;
    logic [N-1:0]        z_q,         z_d;
    logic [CW-1:0]       count_q,     count_d;
    logic                decision_q,  decision_d;
    logic                ambiguous_q, ambiguous_d;
    logic                out_valid_q, out_valid_d;

    logic [CW-1:0]       bundle_cnt;

    bundle_popcount #(.N(N)) u_popcount (
        .bundle_i (bundle_q),
        .count_o  (bundle_cnt)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        pass_d      = pass_q;
        mu_x_d      = mu_x_q;
        mu_y_d      = mu_y_q;
        bundle_d    = bundle_q;
        z_d         = z_q;
        count_d     = count_q;
        decision_d  = decision_q;
        ambiguous_d = ambiguous_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    mu_x_d  = x_i;
                    mu_y_d  = y_i;
                    pass_d  = '0;
                    wait_d  = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Countdown runs MU_LATENCY..0, so each pass spends
                // MU_LATENCY+1 edges with operands stable; the unit's result
                // is sampled on the edge where the count has reached zero.
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    bundle_d = mu_z_i;
                    if (pass_q < LAST_PASS) begin
                        // Restorative pass: bundle drives both NAND inputs.
                        // pass_q < LAST_PASS <= 15 keeps the increment in range.
                        mu_x_d = mu_z_i;
                        mu_y_d = mu_z_i;
                        pass_d = pass_q + PASS_W'(1);
                        wait_d = WAIT_LOAD;
                    end else begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                z_d         = bundle_q;
                count_d     = bundle_cnt;
                // Counts strictly between the thresholds are ambiguous and
                // resolve to 0; only count >= HI yields a logical 1.
                decision_d  = (bundle_cnt >= HI);
                ambiguous_d = (bundle_cnt > LO) && (bundle_cnt < HI);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered ready: high exactly while the sequencer sits in IDLE.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            pass_q      <= '0;
            in_ready_q  <= 1'b0;
            mu_x_q      <= '0;
            mu_y_q      <= '0;
            bundle_q    <= '0;
            z_q         <= '0;
            count_q     <= '0;
            decision_q  <= 1'b0;
            ambiguous_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            pass_q      <= pass_d;
            in_ready_q  <= in_ready_d;
            mu_x_q      <= mu_x_d;
            mu_y_q      <= mu_y_d;
            bundle_q    <= bundle_d;
            z_q         <= z_d;
            count_q     <= count_d;
            decision_q  <= decision_d;
            ambiguous_q <= ambiguous_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mu_x_o      = mu_x_q;
    assign mu_y_o      = mu_y_q;
    assign out_valid_o = out_valid_q;
    assign z_o         = z_q;
    assign count_o     = count_q;
    assign decision_o  = decision_q;
    assign ambiguous_o = ambiguous_q;
    assign pass_o      = pass_q;

endmodule
